lidar_dist_filter: RTL and testbench
====================================

Name: lidar_dist_filter

Overview:
Downstream conditioning stage for the UART LiDAR frame parser. Accepts raw 16-bit distance samples (cm) with a valid strobe and rejects invalid and outlier samples. Produces a 2^LOG2_N-sample moving average and a hysteretic obstacle flag for the motion/control logic.

Parameters:
DW, 16, sample/average width in bits (unsigned cm)
LOG2_N, 3, log2 of window length (default N=8)
MAX_JUMP, 200, max |din - avg| accepted in RUN; larger is an outlier
REJ_LIMIT, 4, consecutive outliers that force a window flush (>=1)
NEAR_CM, 30, too_close sets when avg < NEAR_CM
FAR_CM, 40, too_close clears when avg > FAR_CM (FAR_CM > NEAR_CM)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
din  input  DW  raw distance sample from frame parser
din_vld  input  1  1-cycle strobe, din valid this cycle
avg  output  DW  filtered distance = window_sum >> LOG2_N
avg_stb  output  1  1-cycle pulse when avg updated (RUN only)
avg_valid  output  1  level; high while in RUN (window full)
too_close  output  1  hysteretic obstacle flag
drop  output  1  1-cycle pulse when a sample is discarded (invalid or outlier)

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n). Reset values: avg=0, avg_stb=0, avg_valid=0, too_close=0, drop=0. Internally: state=FILL, sum=0, wr_ptr=0, fill_cnt=0, rej_cnt=0. Ring buffer contents don't matter after reset.
- Storage: N-entry ring buffer of DW bits. Running sum of DW+LOG2_N bits, which never overflows. wr_ptr wraps N-1 -> 0.
- Invalid sample: din==0 or din=={DW{1}}. Response: drop pulses next cycle, no state change, and rej_cnt is not altered.
- FILL state:
  - Each valid sample writes buf[wr_ptr] and sets sum <= sum + din (no subtraction), wr_ptr++, fill_cnt++.
  - No outlier check. avg_stb stays 0.
  - On the sample that makes fill_cnt==N, in the same edge: avg <= new_sum >> LOG2_N, avg_stb=1 next cycle, avg_valid=1, state -> RUN, too_close evaluated.
- RUN state:
  - Outlier test: |din - avg| > MAX_JUMP, computed with sign-safe subtraction.
  - Accepted sample: buf[wr_ptr] <= din; sum <= sum + din - buf[wr_ptr]; avg <= that new sum >> LOG2_N; wr_ptr++; rej_cnt <= 0; avg_stb pulses.
  - Latency: din_vld at edge t -> avg/avg_stb visible after edge t (one register stage).
  - Outlier with rej_cnt < REJ_LIMIT-1: drop pulses, rej_cnt++, avg is unchanged.
  - Outlier with rej_cnt == REJ_LIMIT-1 (flush): buf[0] <= din, sum <= din, wr_ptr=1, fill_cnt=1, rej_cnt=0, avg_valid=0, state -> FILL.
  - A flush has no drop pulse and no avg_stb. avg and too_close hold their last values.
- too_close is evaluated only on an avg update:
  - new avg < NEAR_CM -> 1
  - new avg > FAR_CM -> 0
  - otherwise hold
- Exact thresholds (avg==NEAR_CM or avg==FAR_CM) hold the current value.
- din_vld is sampled every cycle. Back-to-back strobes are fully supported with no stall.
- rst_n asserted mid-FILL or mid-RUN aborts immediately to the reset values above.

Test Plan:
1. Reset, then 8 samples of 100 on consecutive cycles -> avg_stb=0 for the first 7. After the 8th edge: avg=100, avg_stb=1, avg_valid=1, too_close=0.
2. From the state of test 1, feed 108 -> avg=101 (808>>3), avg_stb pulse. Feed 0 and then 0xFFFF -> drop pulses twice, avg stays 101, rej_cnt unchanged.
3. From avg=100 in RUN, feed 400 three times -> 3 drop pulses, avg=100 throughout. A following 100 is accepted and clears rej_cnt. Then four 400s -> 3 drops, and the 4th flushes: avg_valid=0, avg holds 100. Seven more 400s -> avg=400, avg_valid=1.
4. Hysteresis: window of 50s, then feed 25s -> too_close sets on the first update with avg<30. Then feed 35s -> too_close holds at avg 30..40. It clears only once avg reaches 41.
5. Wrap and arithmetic: in RUN, feed 20 samples of 0xFFFE -> avg=0xFFFE with no overflow. wr_ptr wraps with a correct sum (checked against a reference model each cycle).
6. Assert rst_n low mid-FILL (after 5 samples) and again mid-RUN -> all outputs are 0 immediately. The next 8 samples of 60 give avg=60 exactly.

Source files
------------

// File: rtl/lidar_dist_filter.sv
// LiDAR distance conditioner: rejects invalid/outlier samples, keeps a 2^LOG2_N
// moving average over a ring buffer and drives a hysteretic obstacle flag.
module lidar_dist_filter #(
  parameter int unsigned DW        = 16,
  parameter int unsigned LOG2_N    = 3,
  parameter int unsigned MAX_JUMP  = 200,
  parameter int unsigned REJ_LIMIT = 4,
  parameter int unsigned NEAR_CM   = 30,
  parameter int unsigned FAR_CM    = 40
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  input  logic          din_vld,
  output logic [DW-1:0] avg,
  output logic          avg_stb,
  output logic          avg_valid,
  output logic          too_close,
  output logic          drop
);

  localparam int unsigned N  = 1 << LOG2_N;
  localparam int unsigned SW = DW + LOG2_N;
  localparam int unsigned FW = LOG2_N + 1;
  localparam int unsigned RW = (REJ_LIMIT > 1) ? $clog2(REJ_LIMIT) : 1;

  typedef enum logic {S_FILL, S_RUN} state_e;

  state_e              state_q, state_d;
  logic [DW-1:0]       buf_q [N];
  logic [SW-1:0]       sum_q, sum_d;
  logic [LOG2_N-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FW-1:0]       fill_cnt_q, fill_cnt_d;
  logic [RW-1:0]       rej_cnt_q, rej_cnt_d;
  logic [DW-1:0]       avg_q, avg_d;
  logic                avg_stb_q, avg_stb_d;
  logic                avg_valid_q, avg_valid_d;
  logic                too_close_q, too_close_d;
  logic                drop_q, drop_d;

  logic                smp_ok;
  logic [DW-1:0]       diff;
  logic                is_outlier;
  logic                rej_full;
  logic [FW-1:0]       fill_inc;
  logic                fill_done;
  logic                buf_we;
  logic [LOG2_N-1:0]   buf_wa;
  logic                upd;

  // Sample qualification and outlier test shared by next-state and datapath.
  always_comb begin
    smp_ok     = din_vld && (din != '0) && (din != '1);
    diff       = (din >= avg_q) ? (din - avg_q) : (avg_q - din);
    is_outlier = (diff > DW'(MAX_JUMP));
    rej_full   = (rej_cnt_q == RW'(REJ_LIMIT - 1));
    fill_inc   = fill_cnt_q + FW'(1);
    fill_done  = (fill_inc == FW'(N));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FILL;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (smp_ok) begin
      case (state_q)
        S_FILL: if (fill_done) state_d = S_RUN;
        S_RUN:  if (is_outlier && rej_full) state_d = S_FILL;
        default: state_d = S_FILL;
      endcase
    end
  end

  always_comb begin
    sum_d       = sum_q;
    wr_ptr_d    = wr_ptr_q;
    fill_cnt_d  = fill_cnt_q;
    rej_cnt_d   = rej_cnt_q;
    avg_d       = avg_q;
    avg_stb_d   = 1'b0;
    avg_valid_d = avg_valid_q;
    too_close_d = too_close_q;
    drop_d      = 1'b0;
    buf_we      = 1'b0;
    buf_wa      = wr_ptr_q;
    upd         = 1'b0;
    if (din_vld && !smp_ok) begin
      drop_d = 1'b1;
    end else if (smp_ok) begin
      case (state_q)
        S_FILL: begin
          buf_we     = 1'b1;
          sum_d      = sum_q + SW'(din);
          wr_ptr_d   = wr_ptr_q + LOG2_N'(1);
          fill_cnt_d = fill_inc;
          if (fill_done) begin
            upd         = 1'b1;
            avg_valid_d = 1'b1;
          end
        end
        S_RUN: begin
          if (!is_outlier) begin
            buf_we    = 1'b1;
            sum_d     = sum_q + SW'(din) - SW'(buf_q[wr_ptr_q]);
            wr_ptr_d  = wr_ptr_q + LOG2_N'(1);
            rej_cnt_d = '0;
            upd       = 1'b1;
          end else if (rej_full) begin
            // Persistent jump: restart the window from this sample.
            buf_we      = 1'b1;
            buf_wa      = '0;
            sum_d       = SW'(din);
            wr_ptr_d    = LOG2_N'(1);
            fill_cnt_d  = FW'(1);
            rej_cnt_d   = '0;
            avg_valid_d = 1'b0;
          end else begin
            drop_d    = 1'b1;
            rej_cnt_d = rej_cnt_q + RW'(1);
          end
        end
        default: ;
      endcase
    end
    if (upd) begin
      avg_stb_d = 1'b1;
      avg_d     = sum_d[SW-1:LOG2_N];
      if (avg_d < DW'(NEAR_CM))     too_close_d = 1'b1;
      else if (avg_d > DW'(FAR_CM)) too_close_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      wr_ptr_q    <= '0;
      fill_cnt_q  <= '0;
      rej_cnt_q   <= '0;
      avg_q       <= '0;
      avg_stb_q   <= 1'b0;
      avg_valid_q <= 1'b0;
      too_close_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_cnt_q  <= fill_cnt_d;
      rej_cnt_q   <= rej_cnt_d;
      avg_q       <= avg_d;
      avg_stb_q   <= avg_stb_d;
      avg_valid_q <= avg_valid_d;
      too_close_q <= too_close_d;
      drop_q      <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) buf_q[buf_wa] <= din;
  end

  always_comb begin
    avg       = avg_q;
    avg_stb   = avg_stb_q;
    avg_valid = avg_valid_q;
    too_close = too_close_q;
    drop      = drop_q;
  end

endmodule

// File: tb/tb_lidar_dist_filter.sv
// Directed bench for lidar_dist_filter: fill, invalid/outlier rejection, flush,
// hysteresis, saturation-range arithmetic and asynchronous reset.
module tb_lidar_dist_filter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] din = '0;
  logic        din_vld = 1'b0;
  logic [15:0] avg;
  logic        avg_stb, avg_valid, too_close, drop;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lidar_dist_filter #(
    .DW(16), .LOG2_N(3), .MAX_JUMP(200), .REJ_LIMIT(4), .NEAR_CM(30), .FAR_CM(40)
  ) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld),
    .avg(avg), .avg_stb(avg_stb), .avg_valid(avg_valid),
    .too_close(too_close), .drop(drop)
  );

  task automatic send(input logic [15:0] d);
    @(negedge clk);
    din = d; din_vld = 1'b1;
    @(posedge clk);
    #1 din_vld = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({avg, avg_stb, avg_valid, too_close, drop} !== 20'h0) begin
      n_err++; $display("FAIL reset_outputs got=%h exp=0", {avg, avg_stb, avg_valid, too_close, drop});
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      send(16'd100);
      if (i < 7) begin
        n_cmp++;
        if ({avg_stb, avg_valid} !== 2'b00) begin
          n_err++; $display("FAIL fill_early[%0d] stb/valid got=%b exp=00", i, {avg_stb, avg_valid});
        end
      end else begin
        n_cmp++;
        if (avg !== 16'd100) begin n_err++; $display("FAIL fill_avg got=%0d exp=100", avg); end
        n_cmp++;
        if ({avg_stb, avg_valid, too_close} !== 3'b110) begin
          n_err++; $display("FAIL fill_flags got=%b exp=110", {avg_stb, avg_valid, too_close});
        end
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (avg_stb !== 1'b0) begin n_err++; $display("FAIL stb_pulse_width got=%b exp=0", avg_stb); end
  endtask

  task automatic test_invalid();
    logic [15:0] bad [2];
    bad[0] = 16'h0000; bad[1] = 16'hFFFF;
    send(16'd108);
    n_cmp++;
    if (avg !== 16'd101 || avg_stb !== 1'b1) begin
      n_err++; $display("FAIL accept_108 got avg=%0d stb=%b exp avg=101 stb=1", avg, avg_stb);
    end
    for (int i = 0; i < 2; i++) begin
      send(bad[i]);
      n_cmp++;
      if (drop !== 1'b1 || avg_stb !== 1'b0 || avg !== 16'd101) begin
        n_err++; $display("FAIL invalid[%0d] got drop=%b stb=%b avg=%0d exp 1 0 101", i, drop, avg_stb, avg);
      end
    end
    // Invalid sample between outliers must leave the reject count alone.
    send(16'd400); send(16'd400); send(16'd0); send(16'd400);
    n_cmp++;
    if (drop !== 1'b1 || avg_valid !== 1'b1) begin
      n_err++; $display("FAIL rej_after_invalid got drop=%b valid=%b exp 1 1", drop, avg_valid);
    end
    send(16'd400);
    n_cmp++;
    if (drop !== 1'b0 || avg_valid !== 1'b0 || avg !== 16'd101) begin
      n_err++; $display("FAIL flush_after_invalid got drop=%b valid=%b avg=%0d exp 0 0 101", drop, avg_valid, avg);
    end
  endtask

  task automatic test_outlier();
    do_reset();
    for (int i = 0; i < 8; i++) send(16'd100);
    for (int i = 0; i < 3; i++) begin
      send(16'd400);
      n_cmp++;
      if (drop !== 1'b1 || avg !== 16'd100 || avg_valid !== 1'b1) begin
        n_err++; $display("FAIL outlier[%0d] got drop=%b avg=%0d valid=%b exp 1 100 1", i, drop, avg, avg_valid);
      end
    end
    send(16'd100);
    n_cmp++;
    if (avg_stb !== 1'b1 || drop !== 1'b0 || avg !== 16'd100) begin
      n_err++; $display("FAIL accept_clears got stb=%b drop=%b avg=%0d exp 1 0 100", avg_stb, drop, avg);
    end
    for (int i = 0; i < 4; i++) begin
      send(16'd400);
      n_cmp++;
      if (i < 3) begin
        if (drop !== 1'b1 || avg_valid !== 1'b1) begin
          n_err++; $display("FAIL outlier2[%0d] got drop=%b valid=%b exp 1 1", i, drop, avg_valid);
        end
      end else if ({drop, avg_stb, avg_valid} !== 3'b000 || avg !== 16'd100) begin
        n_err++; $display("FAIL flush got drop/stb/valid=%b avg=%0d exp 000 100", {drop, avg_stb, avg_valid}, avg);
      end
    end
    for (int i = 0; i < 7; i++) begin
      send(16'd400);
      n_cmp++;
      if (i < 6) begin
        if ({avg_stb, avg_valid} !== 2'b00 || avg !== 16'd100) begin
          n_err++; $display("FAIL refill[%0d] got stb/valid=%b avg=%0d exp 00 100", i, {avg_stb, avg_valid}, avg);
        end
      end else if (avg !== 16'd400 || {avg_stb, avg_valid} !== 2'b11) begin
        n_err++; $display("FAIL refill_done got avg=%0d stb/valid=%b exp 400 11", avg, {avg_stb, avg_valid});
      end
    end
    send(16'd600);
    n_cmp++;
    if (avg !== 16'd425 || avg_stb !== 1'b1) begin
      n_err++; $display("FAIL jump_eq_max got avg=%0d stb=%b exp 425 1", avg, avg_stb);
    end
    send(16'd626);
    n_cmp++;
    if (drop !== 1'b1 || avg !== 16'd425) begin
      n_err++; $display("FAIL jump_gt_max got drop=%b avg=%0d exp 1 425", drop, avg);
    end
  endtask

  task automatic test_hysteresis();
    int ea [21] = '{46,43,40,37,34,31,28,25, 26,27,28,30,31,32,33,35, 36,37,38,40,41};
    int et [21] = '{0,0,0,0,0,0,1,1, 1,1,1,1,1,1,1,1, 1,1,1,1,0};
    logic [15:0] d;
    do_reset();
    for (int i = 0; i < 8; i++) send(16'd50);
    for (int i = 0; i < 21; i++) begin
      d = (i < 8) ? 16'd25 : (i < 16) ? 16'd35 : 16'd45;
      send(d);
      n_cmp++;
      if (avg !== 16'(ea[i]) || too_close !== et[i][0]) begin
        n_err++; $display("FAIL hyst[%0d] got avg=%0d tc=%b exp avg=%0d tc=%0d", i, avg, too_close, ea[i], et[i]);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 8; i++) send(16'd400);
    for (int i = 0; i < 20; i++) begin
      send(16'hFFFE);
      n_cmp++;
      if (i < 3) begin
        if ({drop, avg_stb, avg_valid} !== 3'b101 || avg !== 16'd400) begin
          n_err++; $display("FAIL wrap_drop[%0d] got dsv=%b avg=%h exp 101 0190", i, {drop, avg_stb, avg_valid}, avg);
        end
      end else if (i < 10) begin
        if ({drop, avg_stb, avg_valid} !== 3'b000 || avg !== 16'd400) begin
          n_err++; $display("FAIL wrap_fill[%0d] got dsv=%b avg=%h exp 000 0190", i, {drop, avg_stb, avg_valid}, avg);
        end
      end else if ({drop, avg_stb, avg_valid} !== 3'b011 || avg !== 16'hFFFE) begin
        n_err++; $display("FAIL wrap_run[%0d] got dsv=%b avg=%h exp 011 fffe", i, {drop, avg_stb, avg_valid}, avg);
      end
    end
  endtask

  task automatic test_midreset();
    do_reset();
    for (int i = 0; i < 5; i++) send(16'd200);
    @(negedge clk); #2 rst_n = 1'b0; #1;
    n_cmp++;
    if ({avg, avg_stb, avg_valid, too_close, drop} !== 20'h0) begin
      n_err++; $display("FAIL midfill_reset got=%h exp=0", {avg, avg_stb, avg_valid, too_close, drop});
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(16'd20);
      n_cmp++;
      if (i < 7) begin
        if (avg_stb !== 1'b0) begin n_err++; $display("FAIL refill20[%0d] stb got=%b exp=0", i, avg_stb); end
      end else if (avg !== 16'd20 || {avg_valid, too_close} !== 2'b11) begin
        n_err++; $display("FAIL refill20_done got avg=%0d v/tc=%b exp 20 11", avg, {avg_valid, too_close});
      end
    end
    @(negedge clk); #2 rst_n = 1'b0; #1;
    n_cmp++;
    if ({avg, avg_stb, avg_valid, too_close, drop} !== 20'h0) begin
      n_err++; $display("FAIL midrun_reset got=%h exp=0", {avg, avg_stb, avg_valid, too_close, drop});
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(16'd60);
      n_cmp++;
      if (i < 7) begin
        if ({avg_stb, avg_valid} !== 2'b00) begin
          n_err++; $display("FAIL refill60[%0d] got stb/valid=%b exp 00", i, {avg_stb, avg_valid});
        end
      end else if (avg !== 16'd60 || {avg_stb, avg_valid, too_close} !== 3'b110) begin
        n_err++; $display("FAIL refill60_done got avg=%0d sv/tc=%b exp 60 110", avg, {avg_stb, avg_valid, too_close});
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_invalid();
    test_outlier();
    test_hysteresis();
    test_wrap();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
